// File: rtl/bridge_pkg.sv
// +--------------------------------------------------------------------------+
// | bridge_pkg: shared types and helpers for the bridge receiver slice.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef WIDTH
`define WIDTH 8
`endif

package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } recv_state_t;

  // Occupancy from wrap-bit pointers: modular difference over pw bits.
  function automatic logic [15:0] ptr_level(input logic [15:0] wr,
                                            input logic [15:0] rd,
                                            input int unsigned pw);
    logic [15:0] diff;
    diff = wr - rd;
    return diff & ((16'd1 << pw) - 16'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bridge_sync_fifo.sv
// +--------------------------------------------------------------------------+
// | bridge_sync_fifo: `WIDTH x DEPTH first-word-fall-through FIFO.            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef WIDTH
`define WIDTH 8
`endif

module bridge_sync_fifo
  import bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [`WIDTH-1:0] push_data,
  input  logic              pop,
  output logic [`WIDTH-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [`WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; the empty gate on pop_data hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = LW'(ptr_level(16'(wr_ptr), 16'(rd_ptr), PW));
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full)) else $error("bridge_sync_fifo overflow");
      assert (!(pop && empty)) else $error("bridge_sync_fifo underflow");
    end
  end

endmodule

`default_nettype wire

// File: rtl/bridge_receiver.sv
// +--------------------------------------------------------------------------+
// | bridge_receiver: valid/ready sink with FWFT buffer, drain FSM and word    |
// | counter. Optional XOR checksum port under RECV_CHECKSUM_EN. Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef WIDTH
`define WIDTH 8
`endif

module bridge_receiver
  import bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     valid,
  input  logic [`WIDTH-1:0]        data_in,
  output logic                     ready,
  output logic [`WIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         rx_count,
  output logic                     busy
`ifdef RECV_CHECKSUM_EN
  ,
  output logic [`WIDTH-1:0]        checksum
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;

  recv_state_t      state_q;
  recv_state_t      state_d;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drain_done;
  logic [CNT_W-1:0] count_q;

  bridge_sync_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Registered-only decode keeps valid out of the ready path.
  assign ready     = (state_q == RECV) && !full;
  assign out_valid = !empty;
  assign push      = valid && ready;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != IDLE);
  assign rx_count  = count_q;

  // True when the buffer is empty once this cycle's pop has taken effect.
  assign drain_done = (level == LW'(0)) || ((level == LW'(1)) && pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RECV;
      RECV:    if (!en) state_d = (level == LW'(0)) ? IDLE : DRAIN;
      DRAIN: begin
        if (drain_done) state_d = IDLE;
        else if (en)    state_d = RECV;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RECV_CHECKSUM_EN
  logic [`WIDTH-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst)       csum_q <= '0;
    else if (push) csum_q <= csum_q ^ data_in;
  end

  assign checksum = csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bridge_receiver.sv
// Directed, table-driven bench for bridge_receiver (DEPTH=4, CNT_W=16, 8-bit words).
`default_nettype none

`ifndef WIDTH
`define WIDTH 8
`endif

module tb_bridge_receiver;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic              clk;
  logic              rst;
  logic              en;
  logic              valid;
  logic [`WIDTH-1:0] data_in;
  logic              ready;
  logic [`WIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        level;
  logic [15:0]       rx_count;
  logic              busy;
`ifdef RECV_CHECKSUM_EN
  logic [`WIDTH-1:0] checksum;
`endif

  int n_checks;
  int n_fail;

  bridge_receiver #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid     (valid),
    .data_in   (data_in),
    .ready     (ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .rx_count  (rx_count),
    .busy      (busy)
`ifdef RECV_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        e;
    logic        v;
    logic [7:0]  d;
    logic        o;
    logic        x_ready;
    logic        x_ov;
    logic [7:0]  x_od;
    logic [2:0]  x_lvl;
    logic [15:0] x_cnt;
    logic        x_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic v,
                      input logic [7:0] d, input logic o);
    @(negedge clk);
    rst = r; en = e; valid = v; data_in = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic x_ready, input logic x_ov,
                           input logic [7:0] x_od, input logic [2:0] x_lvl,
                           input logic [15:0] x_cnt, input logic x_busy);
    check({tag, ".ready"},     32'(ready),     32'(x_ready));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(x_ov));
    check({tag, ".out_data"},  32'(out_data),  32'(x_od));
    check({tag, ".level"},     32'(level),     32'(x_lvl));
    check({tag, ".rx_count"},  32'(rx_count),  32'(x_cnt));
    check({tag, ".busy"},      32'(busy),      32'(x_busy));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; valid = 1'b0; data_in = '0; out_ready = 1'b0;

    //                r  e  v  din    o   rdy ov  odata  lvl   cnt     busy
    vecs[0]  = '{H, H, H, 8'h55, L,  L, L, 8'h00, 3'd0, 16'd0, L}; // reset, valid/en ignored
    vecs[1]  = '{H, H, H, 8'h55, L,  L, L, 8'h00, 3'd0, 16'd0, L};
    vecs[2]  = '{L, H, L, 8'h00, L,  H, L, 8'h00, 3'd0, 16'd0, H}; // IDLE -> RECV
    vecs[3]  = '{L, H, H, 8'hA5, L,  H, H, 8'hA5, 3'd1, 16'd1, H}; // single word
    vecs[4]  = '{L, H, H, 8'h01, L,  H, H, 8'hA5, 3'd2, 16'd2, H};
    vecs[5]  = '{L, H, H, 8'h02, L,  H, H, 8'hA5, 3'd3, 16'd3, H};
    vecs[6]  = '{L, H, H, 8'h03, L,  L, H, 8'hA5, 3'd4, 16'd4, H}; // full
    vecs[7]  = '{L, H, H, 8'h04, L,  L, H, 8'hA5, 3'd4, 16'd4, H}; // 5th word ignored
    vecs[8]  = '{L, H, H, 8'hEE, H,  H, H, 8'h01, 3'd3, 16'd4, H}; // pop while full, no push
    vecs[9]  = '{L, H, L, 8'h00, H,  H, H, 8'h02, 3'd2, 16'd4, H};
    vecs[10] = '{L, H, H, 8'h11, H,  H, H, 8'h03, 3'd2, 16'd5, H}; // push+pop at level 2
    vecs[11] = '{L, H, H, 8'h22, L,  H, H, 8'h03, 3'd3, 16'd6, H};
    vecs[12] = '{L, L, L, 8'h00, L,  L, H, 8'h03, 3'd3, 16'd6, H}; // RECV -> DRAIN
    vecs[13] = '{L, L, H, 8'h99, H,  L, H, 8'h11, 3'd2, 16'd6, H};
    vecs[14] = '{L, L, L, 8'h00, H,  L, H, 8'h22, 3'd1, 16'd6, H};
    vecs[15] = '{L, L, L, 8'h00, H,  L, L, 8'h00, 3'd0, 16'd6, L}; // last pop -> IDLE
    vecs[16] = '{L, L, L, 8'h00, L,  L, L, 8'h00, 3'd0, 16'd6, L};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].d, vecs[i].o);
      check_all($sformatf("vec%0d", i), vecs[i].x_ready, vecs[i].x_ov, vecs[i].x_od,
                vecs[i].x_lvl, vecs[i].x_cnt, vecs[i].x_busy);
    end

    // DRAIN -> RECV when en returns, then reset mid-transfer discards the buffer.
    step(H, L, L, 8'h00, L);
    check_all("rstA", L, L, 8'h00, 3'd0, 16'd0, L);
    step(L, H, L, 8'h00, L);
    step(L, H, H, 8'h31, L);
    step(L, H, H, 8'h32, L);
    check_all("two_words", H, H, 8'h31, 3'd2, 16'd2, H);
    step(L, L, L, 8'h00, L);
    check_all("to_drain", L, H, 8'h31, 3'd2, 16'd2, H);
    step(L, H, L, 8'h00, L);
    check_all("drain_to_recv", H, H, 8'h31, 3'd2, 16'd2, H);
    step(H, H, H, 8'h77, L);
    check_all("mid_reset", L, L, 8'h00, 3'd0, 16'd0, L);

`ifdef RECV_CHECKSUM_EN
    step(L, H, L, 8'h00, L);
    step(L, H, H, 8'h0F, L);
    check("csum_0f", 32'(checksum), 32'h0F);
    step(L, H, H, 8'hF0, L);
    check("csum_ff", 32'(checksum), 32'hFF);
    step(L, H, H, 8'hFF, L);
    check("csum_00", 32'(checksum), 32'h00);
    step(H, L, L, 8'h00, L);
    check("csum_rst", 32'(checksum), 32'h00);
`endif

    // Counter wrap: stream with out_ready held so one push lands every cycle.
    step(H, L, L, 8'h00, L);
    step(L, H, L, 8'h00, H);
    for (int i = 0; i < 65535; i++) begin
      step(L, H, H, 8'(i), H);
    end
    check("cnt_max", 32'(rx_count), 32'hFFFF);
    check("stream_level", 32'(level), 32'd1);
    step(L, H, H, 8'h5A, H);
    check("cnt_wrap", 32'(rx_count), 32'd0);
    check("wrap_head", 32'(out_data), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
